// File: rtl/dmem_wbuf_responder_if.sv
// Data-port bundle between the core (master) and the data-memory responder (slave).
// wb_count width follows WB_DEPTH so it can represent a completely full buffer.
interface dmem_wbuf_responder_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int WB_DEPTH = 4
);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              stall;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output wr, rd, addr, wr_data,
    input  rd_data, rd_valid, stall, wb_count
  );

  modport slave (
    input  wr, rd, addr, wr_data,
    output rd_data, rd_valid, stall, wb_count
  );
endinterface

// File: rtl/dmem_wbuf_responder.sv
// Word SRAM behind a posted write buffer, with a registered read path and store-to-load forwarding.
// Define DMEM_STATS_EN to add saturating 16-bit access/stall statistics outputs.
module dmem_wbuf_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int DEPTH    = 128,
  parameter int WB_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_wbuf_responder_if.slave   bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]            stat_rd,
  output logic [15:0]            stat_wr,
  output logic [15:0]            stat_fwd,
  output logic [15:0]            stat_stall
`endif
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage
  logic [DATA_W-1:0] mem_q     [DEPTH];
  logic [IDX_W-1:0]  wb_idx_q  [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];

  // Buffer control and read-path state
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Decoded request
  logic [IDX_W-1:0]  req_idx;
  logic              full;
  logic              wr_acc;
  logic              rd_acc;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  slot;
  logic              unused_addr_bits;

  assign req_idx          = bus.addr[ADDR_W-1:2];
  assign unused_addr_bits = ^bus.addr[1:0];

  assign full   = (count_q == CNT_W'(WB_DEPTH));
  assign wr_acc = bus.wr && !full;
  assign rd_acc = bus.rd && !full;
  // A full buffer always drains so the stalled request can get in next cycle.
  assign drain  = full || (!rd_acc && (count_q != '0));

  // Scan oldest to youngest so the youngest matching entry wins.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (wb_idx_q[slot] == req_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[slot];
      end
    end
  end

  always_comb begin
    head_d = drain  ? head_q + PTR_W'(1) : head_q;
    tail_d = wr_acc ? tail_q + PTR_W'(1) : tail_q;
    case ({wr_acc, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= fwd_hit ? fwd_data : mem_q[req_idx];
      end
    end
  end

  // NOTE: array and buffer payload are not reset; buffer entries are qualified by count_q instead.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_idx_q[tail_q]  <= req_idx;
      wb_data_q[tail_q] <= bus.wr_data;
    end
    if (drain) begin
      mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.stall    = full && (bus.wr || bus.rd);
  assign bus.wb_count = count_q;

`ifdef DMEM_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q, stat_fwd_q, stat_stall_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_fwd_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= sat_inc(stat_rd_q, rd_acc);
      stat_wr_q    <= sat_inc(stat_wr_q, wr_acc);
      stat_fwd_q   <= sat_inc(stat_fwd_q, rd_acc && fwd_hit);
      stat_stall_q <= sat_inc(stat_stall_q, bus.stall);
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_fwd   = stat_fwd_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed bench for dmem_wbuf_responder: reset, forwarding, duplicates, full-buffer stall, reset mid-drain.
module tb_dmem_wbuf_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_wbuf_responder_if #(.DATA_W(32), .ADDR_W(9), .WB_DEPTH(4)) bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_fwd, stat_stall;
`endif

  dmem_wbuf_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(128), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_STATS_EN
    ,
    .stat_rd    (stat_rd),
    .stat_wr    (stat_wr),
    .stat_fwd   (stat_fwd),
    .stat_stall (stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d);
    bus.wr      = w;
    bus.rd      = r;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'h000, 32'h0);
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    idle();
    while (bus.wb_count != 0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(bus.wb_count), 64'd0);
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    tick();
    idle();
  endtask

  task automatic do_read(input string tag, input logic [8:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, 32'h0);
    tick();
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check(tag, 64'(bus.rd_data), 64'(exp));
    idle();
  endtask

  initial begin
    idle();
    bus.rd = 1'b1;
    tick();
    #1;
    check("rst_rd_data",  64'(bus.rd_data),  64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_wb_count", 64'(bus.wb_count), 64'd0);
    check("rst_stall",    64'(bus.stall),    64'd0);
    idle();
    reset = 1'b0;
    tick();

    // Preload array[4] through the buffer, then read it from the array.
    do_write(9'h010, 32'hDEADBEEF);
    wait_empty("pre4");
    do_read("rd_arr4", 9'h010, 32'hDEADBEEF);
    tick();
    check("idle_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("idle_rd_hold",  64'(bus.rd_data),  64'hDEADBEEF);

    // Store then immediate load: served from the buffer.
    do_write(9'h020, 32'h11111111);
    do_read("fwd_020", 9'h020, 32'h11111111);
    check("fwd_020_pending", 64'(bus.wb_count), 64'd1);
    wait_empty("w020");

    // Duplicate stores to one index: youngest wins, array ends with the later value.
    do_write(9'h040, 32'h0000000A);
    do_write(9'h040, 32'h0000000B);
    do_read("dup_fwd_040", 9'h040, 32'h0000000B);
    wait_empty("w040");
    do_read("dup_arr_040", 9'h040, 32'h0000000B);

    // Five writes with rd held high: buffer fills, fifth write stalls one cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 9'(9'h100 + 4 * i), 32'h50 + 32'(i));
      #1;
      check($sformatf("fill%0d_stall", i), 64'(bus.stall), 64'd0);
      tick();
      check($sformatf("fill%0d_count", i), 64'(bus.wb_count), 64'(i + 1));
      check($sformatf("fill%0d_valid", i), 64'(bus.rd_valid), 64'd1);
    end
    drive(1'b1, 1'b1, 9'h110, 32'h54);
    #1;
    check("full_stall", 64'(bus.stall), 64'd1);
    tick();
    check("full_drain_count", 64'(bus.wb_count), 64'd3);
    check("full_rd_valid",    64'(bus.rd_valid), 64'd0);
    check("full_unstall",     64'(bus.stall),    64'd0);
    tick();
    check("full_accept_count", 64'(bus.wb_count), 64'd4);
    wait_empty("wfill");
    for (int i = 0; i < 5; i++) begin
      do_read($sformatf("fill_arr%0d", i), 9'(9'h100 + 4 * i), 32'h50 + 32'(i));
    end

    // Same-cycle read and write: read gets the old value.
    do_write(9'h080, 32'h5);
    wait_empty("w080");
    drive(1'b1, 1'b1, 9'h080, 32'h6);
    tick();
    check("rw_old_valid", 64'(bus.rd_valid), 64'd1);
    check("rw_old_data",  64'(bus.rd_data),  64'h5);
    check("rw_pending",   64'(bus.wb_count), 64'd1);
    do_read("rw_new_fwd", 9'h080, 32'h6);
    wait_empty("w080b");
    do_read("rw_new_arr", 9'h080, 32'h6);

    // Reset with three writes pending: they must never reach the array.
    for (int i = 0; i < 3; i++) do_write(9'(9'h1A0 + 4 * i), 32'h77);
    wait_empty("w1a0");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 9'(9'h1A0 + 4 * i), 32'hC0 + 32'(i));
      tick();
    end
    check("pre_rst_count", 64'(bus.wb_count), 64'd3);
    check("pre_rst_valid", 64'(bus.rd_valid), 64'd1);
    idle();
    reset = 1'b1;
    #1;
    check("mid_rst_count", 64'(bus.wb_count), 64'd0);
    check("mid_rst_valid", 64'(bus.rd_valid), 64'd0);
    check("mid_rst_data",  64'(bus.rd_data),  64'd0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      do_read($sformatf("rst_lost%0d", i), 9'(9'h1A0 + 4 * i), 32'h77);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf_responder.md
Name: dmem_wbuf_responder

Overview:
- Data-memory responder at the memory end of the core's data port (wr, rd, addr, wr_data, rd_data); replaces the ideal combinational data memory.
- Single-port word SRAM array behind a 4-entry posted write buffer.
- Registered read path with store-to-load forwarding from the buffer.
- stall back to the pipeline when an access cannot be accepted this cycle.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, byte address width; word index = addr[ADDR_W-1:2]
DEPTH, 128, array words (2^(ADDR_W-2))
WB_DEPTH, 4, write-buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr  in  1  store request
rd  in  1  load request
addr  in  ADDR_W  byte address; addr[1:0] ignored
wr_data  in  DATA_W  store data
rd_data  out  DATA_W  load data, registered
rd_valid  out  1  one-cycle pulse, rd_data valid
stall  out  1  combinational; request not accepted this cycle, core must hold it
wb_count  out  $clog2(WB_DEPTH)+1  entries pending in write buffer

Behaviour:
- One clock. Asynchronous, active-high reset.
- Reset values: rd_data=0, rd_valid=0, wb_count=0, stall=0.
- Reset empties the buffer; pending writes are discarded, including mid-drain.
- Array contents are not reset.
- full = (wb_count==WB_DEPTH); stall = full && (wr || rd).
- Array port arbitration, one access per cycle:
  - full: drain wins.
  - otherwise an accepted rd wins.
  - otherwise drain if non-empty.
- Write accept (wr && !full):
  - Enqueue {index, wr_data} at tail.
  - Same-index duplicates are kept and drained in FIFO order.
- Drain: head entry written to array[index]; head advances.
- Enqueue and drain in the same cycle: count unchanged.
- Full with wr: no enqueue. The drain frees one slot, so stall drops the next cycle.
- Read accept (rd && !full): rd_data/rd_valid register at the next edge (latency 1).
  - Data = youngest valid buffer entry with matching index, else array[index].
  - Comparison uses buffer state before this cycle's enqueue.
- rd and wr in the same cycle, not full:
  - Both are accepted.
  - Read returns the pre-write value; the write is enqueued.
- Back-to-back reads: one result per cycle, rd_valid held high.
- rd_valid=0 in any cycle with no accepted read; rd_data holds its last value.
- Pointers wrap modulo WB_DEPTH. wb_count never exceeds WB_DEPTH.
- Index uses addr[ADDR_W-1:2] only; out-of-range cannot occur.

Optional Feature:
Macro DMEM_STATS_EN.
- Defined: adds outputs stat_rd, stat_wr, stat_fwd, stat_stall, each 16 bits, saturating.
  - Count accepted reads, accepted writes, reads served by forwarding, and cycles with stall=1.
  - All reset to 0.
- Undefined: the ports and counters do not exist; remaining behaviour is identical.

Test Plan:
- Reset, then rd addr=0x010 with array[4] preloaded 0xDEADBEEF -> next cycle rd_valid=1, rd_data=0xDEADBEEF; all outputs 0 during reset.
- wr addr=0x020 data=0x11111111, then rd 0x020 the next cycle with no idle gap -> rd_data=0x11111111 (forwarded).
- Two writes to 0x040 (0xA, then 0xB), then rd 0x040 -> 0xB; after drain, array[16]=0xB.
- Writes on 5 consecutive cycles with rd held high throughout:
  - wb_count reaches 4, then stall=1 on the 5th write.
  - The write is accepted one cycle later; no data lost; all 5 values appear in the array in order.
- Same-cycle rd+wr to 0x080 (old 0x5, new 0x6) -> rd_data=0x5; a subsequent rd -> 0x6.
- Assert reset while wb_count=3 -> wb_count=0 immediately; pending writes are absent from the array; rd_valid=0.
